bat_program_loader: RTL and testbench

//  Boot-time program loader in front of the bat_amateur core. Takes a byte stream
//  (valid/ready), holds the core in HALT, writes 16-bit words into core RAM over the

---
 rtl/bat_program_loader_if.sv | 29 ++
 rtl/bat_program_loader.sv | 134 +++++++++++++
 tb/tb_bat_program_loader.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/bat_program_loader_if.sv
// Loader-facing bundle: byte stream in, core control/RAM write port out.
interface bat_program_loader_if;
   logic        START;
   logic [7:0]  RX_DATA;
   // A byte transfers on a rising edge where RX_VALID && RX_READY; the sender
   // holds RX_DATA stable while RX_VALID is high and the loader is not ready.
   logic        RX_VALID;
   logic        RX_READY;
   logic        HALT;
   logic [15:0] ADDRESS;
   logic [15:0] DATA;
   logic        EXT_RAM_RW;
   logic        EXT_RAM_EN;
   logic        CORE_RST;
   logic        DONE;
   logic        ERROR;

   modport master (
      input  START, RX_DATA, RX_VALID,
      output RX_READY, HALT, ADDRESS, DATA, EXT_RAM_RW, EXT_RAM_EN,
             CORE_RST, DONE, ERROR
   );

   modport slave (
      output START, RX_DATA, RX_VALID,
      input  RX_READY, HALT, ADDRESS, DATA, EXT_RAM_RW, EXT_RAM_EN,
             CORE_RST, DONE, ERROR
   );
endinterface

// File: rtl/bat_program_loader.sv
// Boot loader: receives a length-prefixed, checksummed word frame, writes it into
// core RAM while the core is halted, then pulses core reset and lets it run.
module bat_program_loader #(
   parameter logic [15:0] BASE_ADDR   = 16'h0000,
   parameter logic        WRITE_LEVEL = 1'b1,
   parameter int          RST_CYCLES  = 2
) (
   input  logic                 CLK,
   input  logic                 RST,
   bat_program_loader_if.master bus,
   output logic [3:0]           state_dbg
);

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_LEN_HI = 4'd1,
      S_LEN_LO = 4'd2,
      S_DAT_HI = 4'd3,
      S_DAT_LO = 4'd4,
      S_WRITE  = 4'd5,
      S_CSUM   = 4'd6,
      S_CRST   = 4'd7,
      S_RUN    = 4'd8,
      S_ERR    = 4'd9
   } state_t;

   state_t      state;
   logic [15:0] len;
   logic [15:0] count;
   logic [7:0]  sum;
   logic [15:0] rst_cnt;
   logic        accept;

   assign accept    = bus.RX_VALID & bus.RX_READY;
   assign state_dbg = state;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state          <= S_IDLE;
         bus.RX_READY   <= 1'b0;
         bus.HALT       <= 1'b1;
         bus.CORE_RST   <= 1'b1;
         bus.EXT_RAM_EN <= 1'b0;
         bus.EXT_RAM_RW <= ~WRITE_LEVEL;
         bus.ADDRESS    <= BASE_ADDR;
         bus.DATA       <= 16'h0000;
         bus.DONE       <= 1'b0;
         bus.ERROR      <= 1'b0;
         len            <= 16'h0000;
         count          <= 16'h0000;
         sum            <= 8'h00;
         rst_cnt        <= 16'h0000;
      end else begin
         // The write strobe is a single-cycle pulse raised only on entry to WRITE.
         bus.EXT_RAM_EN <= 1'b0;
         bus.EXT_RAM_RW <= ~WRITE_LEVEL;
         case (state)
            S_IDLE, S_RUN, S_ERR: begin
               if (bus.START) begin
                  state        <= S_LEN_HI;
                  bus.RX_READY <= 1'b1;
                  bus.HALT     <= 1'b1;
                  bus.CORE_RST <= 1'b1;
                  bus.DONE     <= 1'b0;
                  bus.ERROR    <= 1'b0;
                  bus.ADDRESS  <= BASE_ADDR;
                  sum          <= 8'h00;
                  count        <= 16'h0000;
               end
            end
            S_LEN_HI: begin
               if (accept) begin
                  len[15:8] <= bus.RX_DATA;
                  state     <= S_LEN_LO;
               end
            end
            S_LEN_LO: begin
               if (accept) begin
                  len[7:0] <= bus.RX_DATA;
                  state    <= ({len[15:8], bus.RX_DATA} == 16'h0000) ? S_CSUM : S_DAT_HI;
               end
            end
            S_DAT_HI: begin
               if (accept) begin
                  bus.DATA[15:8] <= bus.RX_DATA;
                  sum            <= sum + bus.RX_DATA;
                  state          <= S_DAT_LO;
               end
            end
            S_DAT_LO: begin
               if (accept) begin
                  bus.DATA[7:0]  <= bus.RX_DATA;
                  sum            <= sum + bus.RX_DATA;
                  state          <= S_WRITE;
                  bus.RX_READY   <= 1'b0;
                  bus.EXT_RAM_EN <= 1'b1;
                  bus.EXT_RAM_RW <= WRITE_LEVEL;
               end
            end
            S_WRITE: begin
               bus.ADDRESS  <= bus.ADDRESS + 16'd1;
               count        <= count + 16'd1;
               bus.RX_READY <= 1'b1;
               state        <= (count + 16'd1 == len) ? S_CSUM : S_DAT_HI;
            end
            S_CSUM: begin
               if (accept) begin
                  bus.RX_READY <= 1'b0;
                  if (bus.RX_DATA == sum) begin
                     state   <= S_CRST;
                     rst_cnt <= 16'h0000;
                  end else begin
                     state     <= S_ERR;
                     bus.ERROR <= 1'b1;
                  end
               end
            end
            S_CRST: begin
               // HALT and CORE_RST drop together on the last CRST edge.
               if (rst_cnt == 16'(RST_CYCLES - 1)) begin
                  state        <= S_RUN;
                  bus.HALT     <= 1'b0;
                  bus.CORE_RST <= 1'b0;
                  bus.DONE     <= 1'b1;
               end else begin
                  rst_cnt <= rst_cnt + 16'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bat_program_loader.sv
// Directed bench: two loaders (base 0000 and FFFF) fed the same byte stream,
// RAM writes captured by monitors and compared against an expected queue.
module tb_bat_program_loader;

   localparam logic [3:0] ST_IDLE   = 4'd0;
   localparam logic [3:0] ST_LEN_HI = 4'd1;
   localparam logic [3:0] ST_CSUM   = 4'd6;
   localparam logic [3:0] ST_CRST   = 4'd7;
   localparam logic [3:0] ST_RUN    = 4'd8;
   localparam logic [3:0] ST_ERR    = 4'd9;

   logic       clk;
   logic       rst;
   logic [3:0] state0;
   logic [3:0] state1;

   bat_program_loader_if ifc0 ();
   bat_program_loader_if ifc1 ();

   bat_program_loader #(.BASE_ADDR(16'h0000), .WRITE_LEVEL(1'b1), .RST_CYCLES(2)) dut0 (
      .CLK(clk), .RST(rst), .bus(ifc0), .state_dbg(state0)
   );
   bat_program_loader #(.BASE_ADDR(16'hFFFF), .WRITE_LEVEL(1'b1), .RST_CYCLES(2)) dut1 (
      .CLK(clk), .RST(rst), .bus(ifc1), .state_dbg(state1)
   );

   int checks = 0;
   int errors = 0;
   int rdy_viol = 0;
   int rw_viol = 0;
   logic [31:0] exp0_q[$];
   logic [31:0] exp1_q[$];
   logic [31:0] wr0_q[$];
   logic [31:0] wr1_q[$];
   logic [15:0] words[$];

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- write monitors ----------------
   always @(posedge clk) begin
      if (ifc0.EXT_RAM_EN === 1'b1) begin
         wr0_q.push_back({ifc0.ADDRESS, ifc0.DATA});
         if (ifc0.RX_READY !== 1'b0) rdy_viol++;
         if (ifc0.EXT_RAM_RW !== 1'b1) rw_viol++;
      end
      if (ifc1.EXT_RAM_EN === 1'b1) begin
         wr1_q.push_back({ifc1.ADDRESS, ifc1.DATA});
         if (ifc1.RX_READY !== 1'b0) rdy_viol++;
      end
   end

   // ---------------- checker ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic check_writes(input string tag);
      chk({tag, "_nwr0"}, 32'(wr0_q.size()), 32'(exp0_q.size()));
      chk({tag, "_nwr1"}, 32'(wr1_q.size()), 32'(exp1_q.size()));
      while (exp0_q.size() > 0 && wr0_q.size() > 0)
         chk({tag, "_wr0"}, wr0_q.pop_front(), exp0_q.pop_front());
      while (exp1_q.size() > 0 && wr1_q.size() > 0)
         chk({tag, "_wr1"}, wr1_q.pop_front(), exp1_q.pop_front());
      exp0_q.delete(); exp1_q.delete(); wr0_q.delete(); wr1_q.delete();
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_valid(input logic v, input logic [7:0] b);
      ifc0.RX_VALID = v; ifc1.RX_VALID = v;
      ifc0.RX_DATA  = b; ifc1.RX_DATA  = b;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      ifc0.START = 1'b1; ifc1.START = 1'b1;
      @(negedge clk);
      ifc0.START = 1'b0; ifc1.START = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n = 0;
      set_valid(1'b0, 8'h00);
      repeat (gap) @(negedge clk);
      set_valid(1'b1, b);
      while (ifc0.RX_READY !== 1'b1 && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) chk("rx_ready_wait", 32'(ifc0.RX_READY), 32'd1);
      @(negedge clk);
      set_valid(1'b0, 8'h00);
   endtask

   // Sends the frame held in words[], queueing the expected RAM writes.
   task automatic load(input int max_gap, input int stall_k, input bit bad_csum);
      logic [15:0] n16;
      logic [7:0]  s;
      logic [15:0] a1;
      n16 = 16'(words.size());
      s = 8'h00;
      send_byte(n16[15:8], 0);
      send_byte(n16[7:0], (max_gap == 0) ? 0 : int'($urandom_range(max_gap, 0)));
      for (int k = 0; k < words.size(); k++) begin
         a1 = 16'hFFFF + 16'(k);
         exp0_q.push_back({16'(k), words[k]});
         exp1_q.push_back({a1, words[k]});
         s = s + words[k][15:8] + words[k][7:0];
         send_byte(words[k][15:8], (max_gap == 0) ? 0 : int'($urandom_range(max_gap, 0)));
         send_byte(words[k][7:0], (k == stall_k) ? 50 :
                   ((max_gap == 0) ? 0 : int'($urandom_range(max_gap, 0))));
      end
      send_byte(bad_csum ? 8'h00 : s, (max_gap == 0) ? 0 : int'($urandom_range(max_gap, 0)));
   endtask

   // Called at the negedge right after the checksum byte was accepted.
   task automatic run_check(input string tag);
      chk({tag, "_crst_state"}, 32'(state0), 32'(ST_CRST));
      chk({tag, "_crst_halt"}, 32'(ifc0.HALT), 32'd1);
      @(negedge clk);
      chk({tag, "_crst2_halt"}, 32'(ifc0.HALT), 32'd1);
      chk({tag, "_crst2_corerst"}, 32'(ifc0.CORE_RST), 32'd1);
      @(negedge clk);
      chk({tag, "_run_state"}, 32'(state0), 32'(ST_RUN));
      chk({tag, "_run_halt"}, 32'(ifc0.HALT), 32'd0);
      chk({tag, "_run_corerst"}, 32'(ifc0.CORE_RST), 32'd0);
      chk({tag, "_run_done"}, 32'(ifc0.DONE), 32'd1);
      chk({tag, "_run_done1"}, 32'(ifc1.DONE), 32'd1);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst = 1'b1;
      ifc0.START = 1'b0; ifc1.START = 1'b0;
      set_valid(1'b0, 8'h00);
      repeat (3) @(negedge clk);
      rst = 1'b0;

      chk("rst_state", 32'(state0), 32'(ST_IDLE));
      chk("rst_halt", 32'(ifc0.HALT), 32'd1);
      chk("rst_corerst", 32'(ifc0.CORE_RST), 32'd1);
      chk("rst_en", 32'(ifc0.EXT_RAM_EN), 32'd0);
      chk("rst_rw", 32'(ifc0.EXT_RAM_RW), 32'd0);
      chk("rst_addr", 32'(ifc0.ADDRESS), 32'h0000);
      chk("rst_addr1", 32'(ifc1.ADDRESS), 32'hFFFF);
      chk("rst_data", 32'(ifc0.DATA), 32'h0000);
      chk("rst_ready", 32'(ifc0.RX_READY), 32'd0);
      chk("rst_done", 32'(ifc0.DONE), 32'd0);
      chk("rst_error", 32'(ifc0.ERROR), 32'd0);

      // 1) two-word frame, checksum 12+34+AB+CD = BE; dut1 also covers FFFF->0000 wrap
      pulse_start();
      chk("t1_state", 32'(state0), 32'(ST_LEN_HI));
      chk("t1_ready", 32'(ifc0.RX_READY), 32'd1);
      words = '{16'h1234, 16'hABCD};
      load(0, -1, 1'b0);
      run_check("t1");
      check_writes("t1");

      // 2) same frame with a bad checksum
      pulse_start();
      chk("t2_start_done", 32'(ifc0.DONE), 32'd0);
      chk("t2_start_halt", 32'(ifc0.HALT), 32'd1);
      load(0, -1, 1'b1);
      chk("t2_state", 32'(state0), 32'(ST_ERR));
      chk("t2_error", 32'(ifc0.ERROR), 32'd1);
      repeat (4) @(negedge clk);
      chk("t2_error_hold", 32'(ifc0.ERROR), 32'd1);
      chk("t2_halt", 32'(ifc0.HALT), 32'd1);
      chk("t2_corerst", 32'(ifc0.CORE_RST), 32'd1);
      chk("t2_done", 32'(ifc0.DONE), 32'd0);
      check_writes("t2");
      pulse_start();
      chk("t2_error_clr", 32'(ifc0.ERROR), 32'd0);

      // 3) empty frame 00 00 00 straight into CSUM, no writes
      words.delete();
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      chk("t3_csum_state", 32'(state0), 32'(ST_CSUM));
      send_byte(8'h00, 0);
      run_check("t3");
      check_writes("t3");

      // 5) random valid gaps plus a 50-cycle stall inside word 0
      pulse_start();
      words = '{16'hBEEF, 16'h0042, 16'hC001};
      load(3, 0, 1'b0);
      run_check("t5");
      check_writes("t5");

      // 6) reset after the first DAT_HI byte, then a clean reload
      pulse_start();
      send_byte(8'h00, 0);
      send_byte(8'h02, 0);
      send_byte(8'h12, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t6_state", 32'(state0), 32'(ST_IDLE));
      chk("t6_halt", 32'(ifc0.HALT), 32'd1);
      chk("t6_ready", 32'(ifc0.RX_READY), 32'd0);
      chk("t6_data", 32'(ifc0.DATA), 32'h0000);
      set_valid(1'b1, 8'h34);
      repeat (5) @(negedge clk);
      set_valid(1'b0, 8'h00);
      chk("t6_idle_hold", 32'(state0), 32'(ST_IDLE));
      check_writes("t6_abort");
      pulse_start();
      words = '{16'h5A5A, 16'hA5A5};
      load(0, -1, 1'b0);
      run_check("t6");
      check_writes("t6");

      chk("ready_in_write", 32'(rdy_viol), 32'd0);
      chk("rw_level", 32'(rw_viol), 32'd0);
      chk("final_state1", 32'(state1), 32'(ST_RUN));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
